// File: rtl/glb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : glb_arbiter
//  Purpose  : Round-robin arbiter sharing the single-port GLB between
//             NUM_REQ requesters, with locked bursts capped at MAX_BURST
//             beats and read-data routing back to the issuing requester.
//  Revision : 1.0 - initial release
// ============================================================================
module glb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_we,
  input  logic [16*NUM_REQ-1:0] req_addr,
  input  logic [32*NUM_REQ-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [3:0]            glb_w_en,
  output logic [15:0]           glb_address,
  output logic [31:0]           glb_write_data,
  input  logic [31:0]           glb_read_data,
  output logic [2:0]            grant_id,
  output logic                  locked
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Beat counter needs to hold MAX_BURST itself (up to 256).
  localparam logic [8:0] C_MAX_BURST = 9'(MAX_BURST);
  localparam logic [2:0] C_LAST_ID   = 3'(NUM_REQ - 1);
  localparam logic [3:0] C_NUM_REQ   = 4'(NUM_REQ);

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic [8:0]         count_q, count_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic               accept;
  logic [2:0]         sel;
  logic [3:0]         cand;
  logic               sel_last;
  logic [8:0]         count_inc;

  // Pick the beat to accept: the lock owner if locked, else round-robin from ptr+1.
  always_comb begin
    accept = 1'b0;
    sel    = grant_id_q;
    cand   = '0;
    if (state_q == ST_LOCKED) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id_q == 3'(i) && req_valid[i]) begin
          accept = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = {1'b0, ptr_q} + 4'(k);
        if (cand >= C_NUM_REQ) begin
          cand = cand - C_NUM_REQ;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!accept && cand == 4'(i) && req_valid[i]) begin
            accept = 1'b1;
            sel    = 3'(i);
          end
        end
      end
    end
  end

  // Steer the accepted beat onto the GLB port; idle port is driven to zero.
  always_comb begin
    req_ready      = '0;
    glb_w_en       = 4'b0000;
    glb_address    = 16'h0000;
    glb_write_data = 32'h0000_0000;
    sel_last       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && sel == 3'(i)) begin
        req_ready[i]   = 1'b1;
        glb_w_en       = req_we[4*i +: 4];
        glb_address    = req_addr[16*i +: 16];
        glb_write_data = req_wdata[32*i +: 32];
        sel_last       = req_last[i];
      end
    end
  end

  // Next-state: lock on a non-final beat, release on last or when the burst cap is hit.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    count_d     = count_q;
    rsp_valid_d = '0;
    count_inc   = ((state_q == ST_LOCKED) ? count_q : 9'd0) + 9'd1;
    if (accept) begin
      grant_id_d = sel;
      if (glb_w_en == 4'b0000) begin
        rsp_valid_d = req_ready;
      end
      if (sel_last || count_inc == C_MAX_BURST) begin
        // In LOCKED, sel is the owner, so ptr moves to the owner on release.
        state_d = ST_IDLE;
        ptr_d   = sel;
        count_d = '0;
      end else begin
        state_d = ST_LOCKED;
        count_d = count_inc;
      end
    end
  end

  // State registers; reset abandons any burst and drops a pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= C_LAST_ID;
      grant_id_q  <= 3'd0;
      count_q     <= 9'd0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = glb_read_data;
  assign grant_id  = grant_id_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_glb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glb_arbiter
//  Purpose  : Self-checking bench for glb_arbiter. Two instances share the
//             stimulus (MAX_BURST=16 and MAX_BURST=4), each with its own GLB
//             memory and its own reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_glb_arbiter;

  localparam int NREQ = 3;
  localparam int MB_A = 16;
  localparam int MB_B = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [4*NREQ-1:0]   req_we;
  logic [16*NREQ-1:0]  req_addr;
  logic [32*NREQ-1:0]  req_wdata;
  logic [NREQ-1:0]     req_last;

  logic [NREQ-1:0] rdy_a, rsp_v_a, rdy_b, rsp_v_b;
  logic [31:0]     rsp_d_a, wd_a, rd_a, rsp_d_b, wd_b, rd_b;
  logic [3:0]      wen_a, wen_b;
  logic [15:0]     addr_a, addr_b;
  logic [2:0]      gid_a, gid_b;
  logic            lk_a, lk_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  glb_arbiter #(.NUM_REQ(NREQ), .MAX_BURST(MB_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_last(req_last),
    .rsp_valid(rsp_v_a), .rsp_rdata(rsp_d_a), .glb_w_en(wen_a), .glb_address(addr_a),
    .glb_write_data(wd_a), .glb_read_data(rd_a), .grant_id(gid_a), .locked(lk_a)
  );

  glb_arbiter #(.NUM_REQ(NREQ), .MAX_BURST(MB_B)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_last(req_last),
    .rsp_valid(rsp_v_b), .rsp_rdata(rsp_d_b), .glb_w_en(wen_b), .glb_address(addr_b),
    .glb_write_data(wd_b), .glb_read_data(rd_b), .grant_id(gid_b), .locked(lk_b)
  );

  // GLB memories (word index = addr[9:2]; tests only use low addresses).
  logic [31:0] gmem [2][256];
  logic [31:0] mmem [2][256];

  // Single-port GLB: read data registered, byte-enabled write.
  always @(posedge clk) begin
    rd_a <= gmem[0][addr_a[9:2]];
    rd_b <= gmem[1][addr_b[9:2]];
    for (int b = 0; b < 4; b++) begin
      if (wen_a[b] === 1'b1) gmem[0][addr_a[9:2]][8*b +: 8] = wd_a[8*b +: 8];
      if (wen_b[b] === 1'b1) gmem[1][addr_b[9:2]][8*b +: 8] = wd_b[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr [2];
  int          m_owner [2];
  int          m_cnt [2];
  bit          m_lock [2];
  logic [2:0]  m_rsp [2];
  logic [31:0] m_rdata [2];
  bit          chk_en = 1'b0;

  logic [2:0]  o_rdy, o_rsp, o_gid, e_rdy;
  logic        o_lk;
  logic [3:0]  o_wen, e_we;
  logic [15:0] o_addr, e_addr;
  logic [31:0] o_wd, o_rd, e_wd;
  int          w, n, c, mb;
  string       tag;

  // Compare both DUTs against the model mid-cycle, then advance the model.
  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (j == 0) begin
        o_rdy = rdy_a; o_rsp = rsp_v_a; o_rd = rsp_d_a; o_wen = wen_a; o_addr = addr_a;
        o_wd = wd_a; o_gid = gid_a; o_lk = lk_a; mb = MB_A; tag = "A";
      end else begin
        o_rdy = rdy_b; o_rsp = rsp_v_b; o_rd = rsp_d_b; o_wen = wen_b; o_addr = addr_b;
        o_wd = wd_b; o_gid = gid_b; o_lk = lk_b; mb = MB_B; tag = "B";
      end
      w = -1;
      if (m_lock[j]) begin
        if (req_valid[m_owner[j]]) w = m_owner[j];
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_ptr[j] + k) % NREQ;
          if (w < 0 && req_valid[c]) w = c;
        end
      end
      if (w >= 0) begin
        e_rdy  = 3'(1 << w);
        e_we   = req_we[4*w +: 4];
        e_addr = req_addr[16*w +: 16];
        e_wd   = req_wdata[32*w +: 32];
      end else begin
        e_rdy = 3'b000; e_we = 4'h0; e_addr = 16'h0; e_wd = 32'h0;
      end
      if (chk_en) begin
        chk({tag, "_req_ready"}, o_rdy, e_rdy);
        chk({tag, "_glb_w_en"}, o_wen, e_we);
        chk({tag, "_glb_address"}, o_addr, e_addr);
        chk({tag, "_glb_write_data"}, o_wd, e_wd);
        chk({tag, "_locked"}, o_lk, m_lock[j]);
        chk({tag, "_grant_id"}, o_gid, m_owner[j]);
        chk({tag, "_rsp_valid"}, o_rsp, m_rsp[j]);
        if (m_rsp[j] != 3'b000) chk({tag, "_rsp_rdata"}, o_rd, m_rdata[j]);
      end
      m_rsp[j] = 3'b000;
      if (w >= 0) begin
        n = (m_lock[j] ? m_cnt[j] : 0) + 1;
        m_owner[j] = w;
        if (req_last[w] || n >= mb) begin
          m_lock[j] = 1'b0;
          m_ptr[j]  = w;
        end else begin
          m_lock[j] = 1'b1;
          m_cnt[j]  = n;
        end
        if (e_we == 4'h0) begin
          m_rsp[j]   = e_rdy;
          m_rdata[j] = mmem[j][e_addr[9:2]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (e_we[b]) mmem[j][e_addr[9:2]][8*b +: 8] = e_wd[8*b +: 8];
        end
      end
      if (rst) begin
        m_lock[j] = 1'b0; m_ptr[j] = NREQ - 1; m_owner[j] = 0; m_cnt[j] = 0; m_rsp[j] = 3'b000;
      end
    end
    if (rst) chk_en = 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] we,
                         input logic [15:0] a, input logic [31:0] d, input logic l);
    req_valid[i]         = v;
    req_we[4*i +: 4]     = we;
    req_addr[16*i +: 16] = a;
    req_wdata[32*i +: 32] = d;
    req_last[i]          = l;
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_last = '0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    gmem[0][a[9:2]] = d; gmem[1][a[9:2]] = d;
    mmem[0][a[9:2]] = d; mmem[1][a[9:2]] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    tick();
    rst = 1'b0;
  endtask

  int fexp [6] = '{0, 1, 2, 0, 1, 2};
  int first0;

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    clear_reqs();
    for (int i = 0; i < 256; i++) begin
      gmem[0][i] = 32'h0; gmem[1][i] = 32'h0; mmem[0][i] = 32'h0; mmem[1][i] = 32'h0;
    end
    for (int j = 0; j < 2; j++) begin
      m_ptr[j] = NREQ - 1; m_owner[j] = 0; m_cnt[j] = 0; m_lock[j] = 1'b0;
      m_rsp[j] = 3'b000; m_rdata[j] = 32'h0;
    end
    preload(16'h0010, 32'hDEADBEEF);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_locked", lk_a, 1'b0);
    chk("reset_grant_id", gid_a, 3'd0);
    chk("reset_rsp_valid", rsp_v_a, 3'b000);
    chk("reset_ready", rdy_a, 3'b000);

    // Single read
    tick();
    set_req(0, 1'b1, 4'h0, 16'h0010, 32'h0, 1'b1);
    #1 chk("single_ready", rdy_a, 3'b001);
    tick();
    clear_reqs();
    #1;
    chk("single_rsp_valid", rsp_v_a, 3'b001);
    chk("single_rdata", rsp_d_a, 32'hDEADBEEF);
    chk("single_locked", lk_a, 1'b0);

    // Round-robin fairness from a fresh reset
    tick();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 4'h0, 16'(16'h0040 + 4*i), 32'h0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fair_onehot", 32'($onehot0(rdy_a)), 32'd1);
      chk("fair_grant", rdy_a, 32'd1 << fexp[k]);
      tick();
    end
    clear_reqs();

    // Locked 4-beat write burst by req1 while req0 waits
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1'b1, 4'hF, 16'(16'h0100 + 4*k), 32'hB000_0000 + 32'(k), (k == 3));
      if (k == 1) set_req(0, 1'b1, 4'h0, 16'h0010, 32'h0, 1'b1);
      #1;
      chk("burst_ready", rdy_a, 3'b010);
      if (k > 0) chk("burst_locked", lk_a, 1'b1);
      tick();
    end
    set_req(1, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
    #1;
    chk("burst_release_ready", rdy_a, 3'b001);
    chk("burst_release_locked", lk_a, 1'b0);
    tick();
    set_req(0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1'b1, 4'h0, 16'(16'h0100 + 4*k), 32'h0, (k == 3));
      #1;
      chk("readback_ready", rdy_a, 3'b010);
      if (k == 0) begin
        chk("readback_prev_rsp", rsp_v_a, 3'b001);
      end else begin
        chk("readback_rsp_valid", rsp_v_a, 3'b010);
        chk("readback_rdata", rsp_d_a, 32'hB000_0000 + 32'(k - 1));
      end
      tick();
    end
    clear_reqs();
    #1;
    chk("readback_rsp_valid", rsp_v_a, 3'b010);
    chk("readback_rdata", rsp_d_a, 32'hB000_0003);

    // Byte enables
    set_req(0, 1'b1, 4'hF, 16'h0020, 32'hAAAAAAAA, 1'b1);
    tick();
    set_req(0, 1'b1, 4'b0101, 16'h0020, 32'h11223344, 1'b1);
    tick();
    set_req(0, 1'b1, 4'h0, 16'h0020, 32'h0, 1'b1);
    tick();
    clear_reqs();
    #1;
    chk("be_rsp_valid", rsp_v_a, 3'b001);
    chk("be_rdata", rsp_d_a, 32'hAA22AA44);

    // Forced release: req2 streams without last, req0 waiting
    set_req(2, 1'b1, 4'hF, 16'h0200, 32'h5A5A0000, 1'b0);
    first0 = 0;
    for (int cy = 1; cy <= 8; cy++) begin
      if (cy == 2) set_req(0, 1'b1, 4'h0, 16'h0010, 32'h0, 1'b1);
      #1;
      if (first0 == 0 && rdy_b[0]) first0 = cy;
      if (cy == 5) chk("forced_unlocked_b", lk_b, 1'b0);
      if (cy == 6) chk("forced_resume_b", rdy_b, 3'b100);
      chk("forced_hold_a", rdy_a, 3'b100);
      tick();
    end
    chk("forced_first_req0_b", first0, 32'd5);

    // Reset mid-burst with a read accepted in the reset cycle
    rst = 1'b1;
    set_req(2, 1'b1, 4'h0, 16'h0200, 32'h0, 1'b0);
    #1;
    chk("rstmid_ready_a", rdy_a, 3'b100);
    chk("rstmid_ready_b", rdy_b, 3'b100);
    chk("rstmid_locked_a", lk_a, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_rsp_a", rsp_v_a, 3'b000);
    chk("rstmid_rsp_b", rsp_v_b, 3'b000);
    chk("rstmid_locked_a", lk_a, 1'b0);
    chk("rstmid_grant_a", rdy_a, 3'b001);
    chk("rstmid_grant_b", rdy_b, 3'b001);
    tick();
    clear_reqs();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/glb_arbiter.md
Name: glb_arbiter

Overview:
- Round-robin arbiter that shares the single-port GLB (16-bit byte address, 32-bit data, 4-bit byte write enable, read data valid one cycle after the address) between NUM_REQ requesters, e.g. DMA, PE-array ifmap/weight fetch and psum writeback.
- Supports locked bursts: a granted requester keeps the GLB until it sends its last beat, or until MAX_BURST beats have been accepted.
- Routes the registered GLB read data back to the requester that issued the read.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MAX_BURST, 16, maximum beats per grant before forced release (1..256).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  beat request, one bit per requester
- req_ready  out  NUM_REQ  beat accepted this cycle (combinational)
- req_we  in  4*NUM_REQ  byte write enable per requester, slice i = [4i+3:4i]; 0000 means read
- req_addr  in  16*NUM_REQ  byte address per requester
- req_wdata  in  32*NUM_REQ  write data per requester
- req_last  in  NUM_REQ  beat is the last of its burst
- rsp_valid  out  NUM_REQ  read data valid for requester i (registered)
- rsp_rdata  out  32  read data, shared by all requesters
- glb_w_en  out  4  to GLB w_en
- glb_address  out  16  to GLB address
- glb_write_data  out  32  to GLB write_data
- glb_read_data  in  32  from GLB read_data
- grant_id  out  3  current or most recent owner
- locked  out  1  a burst is in progress

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, priority pointer ptr=NUM_REQ-1, so requester 0 is searched first.
  - Beat counter=0, rsp_valid=0, grant_id=0, locked=0.
  - Any burst in progress is abandoned.
  - A read accepted in the reset cycle produces no rsp_valid.
- State machine: IDLE, LOCKED.
- IDLE:
  - Winner = first i with req_valid[i]=1, searched ptr+1, ptr+2, … modulo NUM_REQ.
  - req_ready[winner]=1 in the same cycle (zero-bubble); all other req_ready bits are 0.
  - No valid request: all req_ready=0, glb_w_en=0.
  - On accept with req_last=1 or MAX_BURST=1: stay IDLE, ptr<=winner, grant_id<=winner.
  - On accept otherwise: go to LOCKED, owner=grant_id<=winner, count<=1.
- LOCKED:
  - req_ready[owner]=req_valid[owner]; all other req_ready bits are 0.
  - Owner deasserts req_valid: lock is held, no beat is issued, glb_w_en=0.
  - Each accept does count+1.
  - Release to IDLE with ptr<=owner when the accepted beat has req_last=1 or count+1==MAX_BURST (forced release).
  - The requester must re-request to continue after a forced release.
- locked=1 exactly in LOCKED.
- GLB drive (combinational, from the accepted beat):
  - glb_address=req_addr slice, glb_write_data=req_wdata slice, glb_w_en=req_we slice.
  - No beat accepted: glb_w_en=0000, glb_address=0, glb_write_data=0.
- Read response:
  - A beat accepted at cycle t with req_we=0000 sets rsp_valid[i]=1 at t+1 for exactly one cycle.
  - rsp_rdata=glb_read_data (passthrough). Data reflects the address presented at t.
  - Back-to-back reads give rsp_valid on consecutive cycles.
  - Writes produce no response.
- Ordering: the GLB has no internal hazard, so a read at t+1 after a write at t to the same address returns the new data. The arbiter adds no buffering.
- At most one GLB access per cycle. Never more than one req_ready bit high.
- Requester obligation: addr/we/wdata/last stable while req_valid=1 and req_ready=0.

Test Plan:
- Single read: reset, req0 valid, addr 0x0010, we=0000, last=1, memory holds 0xDEADBEEF
  -> req_ready[0]=1 same cycle; rsp_valid[0]=1 next cycle with rsp_rdata=0xDEADBEEF; locked stays 0.
- Round-robin fairness: req0, req1 and req2 all valid continuously with single-beat last=1
  -> grants in order 0,1,2,0,1,2; never two req_ready bits high.
- Locked burst: req1 issues 4 writes to 0x0100/0x0104/0x0108/0x010C (last on beat 4) while req0 is valid
  -> req0 not granted until the cycle after beat 4; locked=1 for beats 2–4; readback returns the written words.
- Forced release: MAX_BURST=4, req2 streams 6 beats with last never set, req0 waiting
  -> after req2's 4th beat, req0 wins the next cycle; req2 resumes later.
- Byte enables: write 0x11223344 with we=0101 over 0xAAAAAAAA, then read
  -> rsp_rdata=0xAA22AA44.
- Reset mid-burst: rst during LOCKED with a read accepted in the same cycle
  -> next cycle state=IDLE, rsp_valid=0, req0 granted first.
